// File: rtl/life_pkg.sv
`default_nettype none
// ============================================================================
// Module      : life_pkg
// Description : Shared types and constants for the Game-of-Life frame
//               stepper: FSM state encoding, neighbour count type, default
//               B3/S23 rule masks and the bit order of the neighbour vector.
// Revision    : 1.0 - initial release
// ============================================================================
package life_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  // Live-neighbour count, 0..8
  typedef logic [3:0] count_t;

  // Bit n set: a cell with n live neighbours is born / survives
  localparam logic [8:0] DEF_BIRTH_MASK   = 9'b000001000;
  localparam logic [8:0] DEF_SURVIVE_MASK = 9'b000001100;

  // Bit positions inside the 8-bit neighbour vector
  localparam int unsigned NB_N  = 0;
  localparam int unsigned NB_NE = 1;
  localparam int unsigned NB_E  = 2;
  localparam int unsigned NB_SE = 3;
  localparam int unsigned NB_S  = 4;
  localparam int unsigned NB_SW = 5;
  localparam int unsigned NB_W  = 6;
  localparam int unsigned NB_NW = 7;

endpackage
`default_nettype wire

// File: rtl/life_rule.sv
`default_nettype none
// ============================================================================
// Module      : life_rule
// Description : Combinational Game-of-Life rule. Counts the already
//               border-masked neighbours and looks the result up in the
//               survive mask (live centre) or the birth mask (dead centre).
// Ports       : alive_i        centre cell state
//               nbr_i[7:0]     masked neighbours (order from life_pkg)
//               birth_mask_i   bit n: dead cell with n neighbours is born
//               survive_mask_i bit n: live cell with n neighbours survives
//               next_o         next-generation state of the centre cell
// Revision    : 1.0 - initial release
// ============================================================================
module life_rule
  import life_pkg::*;
(
  input  logic       alive_i,
  input  logic [7:0] nbr_i,
  input  logic [8:0] birth_mask_i,
  input  logic [8:0] survive_mask_i,
  output logic       next_o
);

  count_t count;

  always_comb begin
    count = '0;
    for (int i = 0; i < 8; i++) begin
      count = count + count_t'(nbr_i[i]);
    end
  end

  assign next_o = alive_i ? survive_mask_i[count] : birth_mask_i[count];

endmodule
`default_nettype wire

// File: rtl/life_frame_stepper.sv
`default_nettype none
// ============================================================================
// Module      : life_frame_stepper
// Description : Streams one Game-of-Life generation. Accepts a WIDTH x HEIGHT
//               grid in raster order and emits the next generation in the
//               same order through a one-stage ready/valid output register.
// Ports       : clk_i          clock, rising edge
//               rst_n_i        asynchronous active-low reset
//               start_i        begin a frame (sampled in IDLE only)
//               in_cell_i      current-generation cell, raster order
//               in_valid_i     in_cell_i valid
//               in_ready_o     stepper accepts in_cell_i this cycle
//               out_cell_o     next-generation cell, raster order
//               out_valid_o    out_cell_o valid
//               out_ready_i    sink accepts out_cell_o
//               out_last_o     out_cell_o is the final cell of the frame
//               busy_o         frame in progress
//               done_o         final output accepted this cycle
//               gen_count_o    completed frames, wraps
// Revision    : 1.0 - initial release
// ============================================================================
module life_frame_stepper
  import life_pkg::*;
#(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned HEIGHT       = 16,
  parameter int unsigned GEN_W        = 16,
  parameter logic [8:0]  BIRTH_MASK   = DEF_BIRTH_MASK,
  parameter logic [8:0]  SURVIVE_MASK = DEF_SURVIVE_MASK
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             in_cell_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic             out_cell_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_last_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [GEN_W-1:0] gen_count_o
);

  localparam int unsigned NCELLS  = WIDTH * HEIGHT;
  localparam int unsigned WIN_LEN = 2 * WIDTH + 3;
  localparam int unsigned CTR     = WIDTH + 1;
  localparam int unsigned CNT_W   = $clog2(NCELLS + 1);
  localparam int unsigned ROW_W   = $clog2(HEIGHT);
  localparam int unsigned COL_W   = $clog2(WIDTH);

  localparam logic [CNT_W-1:0] C_FILL_LAST = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] C_CELL_LAST = CNT_W'(NCELLS - 1);
  localparam logic [CNT_W-1:0] C_NCELLS    = CNT_W'(NCELLS);
  localparam logic [ROW_W-1:0] C_ROW_LAST  = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0] C_COL_LAST  = COL_W'(WIDTH - 1);

  state_t             state_q,     state_d;
  logic [WIN_LEN-2:0] win_q,       win_d;
  logic [CNT_W-1:0]   in_cnt_q,    in_cnt_d;
  logic [CNT_W-1:0]   out_cnt_q,   out_cnt_d;
  logic [ROW_W-1:0]   row_q,       row_d;
  logic [COL_W-1:0]   col_q,       col_d;
  logic               out_valid_q, out_valid_d;
  logic               out_cell_q,  out_cell_d;
  logic               out_last_q,  out_last_d;
  logic [GEN_W-1:0]   gen_q,       gen_d;

  logic               w_out_free;
  logic               w_in_ready;
  logic               w_in_fire;
  logic               w_flush_step;
  logic               w_emit;
  logic               w_done;
  logic               w_in_bit;
  logic [WIN_LEN-1:0] w_win;
  logic               w_top, w_bot, w_left, w_right;
  logic [7:0]         w_nbr;
  logic               w_next;

  // Output stage can take a new cell when empty or being drained this cycle
  assign w_out_free   = !out_valid_q || out_ready_i;
  assign w_in_ready   = (state_q == FILL) || ((state_q == RUN) && w_out_free);
  assign w_in_fire    = w_in_ready && in_valid_i;
  assign w_flush_step = (state_q == FLUSH) && w_out_free && (out_cnt_q != C_NCELLS);
  assign w_emit       = ((state_q == RUN) && w_in_fire) || w_flush_step;
  assign w_done       = out_valid_q && out_last_q && out_ready_i;

  // The register holds the 2*WIDTH+2 previous cells; together with the cell
  // entering this cycle it forms the full window, so the output loaded at
  // this edge belongs to the centre of the post-shift window.
  assign w_in_bit = (state_q == FLUSH) ? 1'b0 : in_cell_i;
  assign w_win    = {win_q, w_in_bit};

  assign w_top   = (row_q == '0);
  assign w_bot   = (row_q == C_ROW_LAST);
  assign w_left  = (col_q == '0);
  assign w_right = (col_q == C_COL_LAST);

  // Older cells sit at higher window positions: north row is +WIDTH from
  // the centre, south row is -WIDTH.
  always_comb begin
    w_nbr        = '0;
    w_nbr[NB_N]  = w_win[CTR + WIDTH]     & ~w_top;
    w_nbr[NB_NE] = w_win[CTR + WIDTH - 1] & ~w_top & ~w_right;
    w_nbr[NB_E]  = w_win[CTR - 1]         & ~w_right;
    w_nbr[NB_SE] = w_win[CTR - WIDTH - 1] & ~w_bot & ~w_right;
    w_nbr[NB_S]  = w_win[CTR - WIDTH]     & ~w_bot;
    w_nbr[NB_SW] = w_win[CTR - WIDTH + 1] & ~w_bot & ~w_left;
    w_nbr[NB_W]  = w_win[CTR + 1]         & ~w_left;
    w_nbr[NB_NW] = w_win[CTR + WIDTH + 1] & ~w_top & ~w_left;
  end

  life_rule u_rule (
    .alive_i        (w_win[CTR]),
    .nbr_i          (w_nbr),
    .birth_mask_i   (BIRTH_MASK),
    .survive_mask_i (SURVIVE_MASK),
    .next_o         (w_next)
  );

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    row_d       = row_q;
    col_d       = col_q;
    out_valid_d = out_valid_q;
    out_cell_d  = out_cell_q;
    out_last_d  = out_last_q;
    gen_d       = gen_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d   = FILL;
          win_d     = '0;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          row_d     = '0;
          col_d     = '0;
        end
      end
      FILL: begin
        if (w_in_fire) begin
          win_d    = w_win[WIN_LEN-2:0];
          in_cnt_d = in_cnt_q + CNT_W'(1);
          if (in_cnt_q == C_FILL_LAST) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (w_in_fire) begin
          win_d    = w_win[WIN_LEN-2:0];
          in_cnt_d = in_cnt_q + CNT_W'(1);
          if (in_cnt_q == C_CELL_LAST) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (w_flush_step) begin
          win_d = w_win[WIN_LEN-2:0];
        end
        if (w_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (w_emit) begin
      out_valid_d = 1'b1;
      out_cell_d  = w_next;
      out_last_d  = (out_cnt_q == C_CELL_LAST);
      out_cnt_d   = out_cnt_q + CNT_W'(1);
      if (w_right) begin
        col_d = '0;
        row_d = row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    if (w_done) begin
      gen_d = gen_q + GEN_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      win_q       <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      row_q       <= '0;
      col_q       <= '0;
      out_valid_q <= 1'b0;
      out_cell_q  <= 1'b0;
      out_last_q  <= 1'b0;
      gen_q       <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      row_q       <= row_d;
      col_q       <= col_d;
      out_valid_q <= out_valid_d;
      out_cell_q  <= out_cell_d;
      out_last_q  <= out_last_d;
      gen_q       <= gen_d;
    end
  end

  assign in_ready_o  = w_in_ready;
  assign out_cell_o  = out_cell_q;
  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = w_done;
  assign gen_count_o = gen_q;

endmodule
`default_nettype wire

// File: tb/tb_life_frame_stepper.sv
`default_nettype none
// ============================================================================
// Module      : tb_life_frame_stepper
// Description : Self-checking bench for life_frame_stepper. A 5x5 instance is
//               checked against a grid-level Game-of-Life model; a 2x2
//               instance covers the smallest legal grid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_life_frame_stepper;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 5x5 instance
  logic        a_start, a_in_cell, a_in_valid, a_in_ready;
  logic        a_out_cell, a_out_valid, a_out_ready, a_out_last;
  logic        a_busy, a_done;
  logic [15:0] a_gen;

  // 2x2 instance
  logic        b_start, b_in_cell, b_in_valid, b_in_ready;
  logic        b_out_cell, b_out_valid, b_out_ready, b_out_last;
  logic        b_busy, b_done;
  logic [15:0] b_gen;

  life_frame_stepper #(.WIDTH(5), .HEIGHT(5), .GEN_W(16)) u_dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(a_start),
    .in_cell_i(a_in_cell), .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
    .out_cell_o(a_out_cell), .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
    .out_last_o(a_out_last), .busy_o(a_busy), .done_o(a_done), .gen_count_o(a_gen)
  );

  life_frame_stepper #(.WIDTH(2), .HEIGHT(2), .GEN_W(16)) u_dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(b_start),
    .in_cell_i(b_in_cell), .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .out_cell_o(b_out_cell), .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
    .out_last_o(b_out_last), .busy_o(b_busy), .done_o(b_done), .gen_count_o(b_gen)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Grid-level model: bit r*5+c is cell (r,c); cells off the grid are dead
  function automatic logic [24:0] life_next(input logic [24:0] g);
    logic [24:0] nx;
    int n, rr, cc;
    nx = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if ((dr != 0 || dc != 0) && rr >= 0 && rr < 5 && cc >= 0 && cc < 5)
              n += int'(g[rr*5+cc]);
          end
        end
        if (g[r*5+c]) nx[r*5+c] = (n == 2) || (n == 3);
        else          nx[r*5+c] = (n == 3);
      end
    end
    return nx;
  endfunction

  localparam logic [24:0] BLINKER = 25'h0021080;   // (1,2),(2,2),(3,2)
  localparam logic [24:0] BLOCK   = 25'h0000063;   // (0,0),(0,1),(1,0),(1,1)
  localparam logic [24:0] ALL     = 25'h1FFFFFF;

  // ---------------- 5x5 compare process ----------------
  logic [24:0] exp_cells;
  bit          mon_en = 1'b0;
  int          out_idx = 0;
  int          done_cnt = 0;
  bit          prev_stall = 1'b0;
  logic [2:0]  prev_vals = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("hold_stable", {29'd0, a_out_valid, a_out_cell, a_out_last}, {29'd0, prev_vals});
      if (mon_en && a_out_valid && a_out_ready) begin
        if (out_idx >= 25) begin
          chk("extra_output", out_idx, 24);
        end else begin
          chk("out_cell", a_out_cell, exp_cells[out_idx]);
          chk("out_last", a_out_last, (out_idx == 24));
          chk("done",     a_done,     (out_idx == 24));
          out_idx++;
        end
      end
      if (a_done) done_cnt++;
      prev_stall = a_out_valid && !a_out_ready;
      prev_vals  = {a_out_valid, a_out_cell, a_out_last};
    end
  end

  // ---------------- 2x2 collector ----------------
  logic [1:0] b_outs[$];
  int         b_done_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (b_out_valid && b_out_ready) b_outs.push_back({b_out_cell, b_out_last});
      if (b_done) b_done_cnt++;
    end
  end

  task automatic run_frame(input logic [24:0] g, input int gap_pct, input int stall_pct,
                           input int abort_after, input bit mid_start);
    int k;
    int cyc;
    bit fire;
    exp_cells = life_next(g);
    out_idx   = 0;
    done_cnt  = 0;
    mon_en    = (abort_after < 0);
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    chk("busy_after_start", a_busy, 1);
    k = 0;
    cyc = 0;
    while (k < 25 && k != abort_after) begin
      a_in_valid  = (gap_pct == 0) || ($urandom_range(99) >= gap_pct);
      a_in_cell   = g[k];
      a_out_ready = (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
      a_start     = mid_start && (k == 12);
      @(negedge clk);
      fire = a_in_valid && a_in_ready;
      @(posedge clk); #1;
      if (fire) k++;
      cyc++;
      if (cyc > 2000) begin
        chk("input_timeout", k, 25);
        break;
      end
    end
    a_in_valid = 1'b0;
    a_start    = 1'b0;
    if (abort_after >= 0) return;
    cyc = 0;
    while (out_idx < 25 && cyc < 2000) begin
      a_out_ready = (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
      @(posedge clk); #1;
      cyc++;
    end
    chk("outputs_seen", out_idx, 25);
    chk("busy_after_done", a_busy, 0);
    chk("done_pulses", done_cnt, 1);
    a_out_ready = 1'b1;
    mon_en = 1'b0;
  endtask

  initial begin
    int k;
    int cyc;
    bit fire;
    rst_n = 1'b0;
    a_start = 0; a_in_cell = 0; a_in_valid = 0; a_out_ready = 1;
    b_start = 0; b_in_cell = 0; b_in_valid = 0; b_out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_cell",  a_out_cell,  0);
    chk("rst_out_last",  a_out_last,  0);
    chk("rst_in_ready",  a_in_ready,  0);
    chk("rst_busy",      a_busy,      0);
    chk("rst_done",      a_done,      0);
    chk("rst_gen",       a_gen,       0);
    @(negedge clk) rst_n = 1'b1;

    // Pin the model with hand-derived generations
    chk("model_blinker", life_next(BLINKER), 32'h0003800);  // idx 11,12,13
    chk("model_block",   life_next(BLOCK),   32'h0000063);
    chk("model_all",     life_next(ALL),     32'h1100011);  // idx 0,4,20,24

    // 1: blinker
    run_frame(BLINKER, 0, 0, -1, 1'b0);
    chk("gen_t1", a_gen, 1);
    // 2 + 6a: corner block, START pulsed mid-frame
    run_frame(BLOCK, 0, 0, -1, 1'b1);
    chk("gen_t2", a_gen, 2);
    // 3: all live
    run_frame(ALL, 0, 0, -1, 1'b0);
    chk("gen_t3", a_gen, 3);
    // 4: blinker with input gaps and output backpressure
    run_frame(BLINKER, 30, 50, -1, 1'b0);
    chk("gen_t4", a_gen, 4);

    // 5: reset mid-frame after 10 inputs, then a fresh frame
    run_frame(BLINKER, 0, 0, 10, 1'b0);
    chk("busy_mid_frame", a_busy, 1);
    #2 rst_n = 1'b0;
    #2;
    chk("abort_busy",      a_busy,      0);
    chk("abort_gen",       a_gen,       0);
    chk("abort_out_valid", a_out_valid, 0);
    chk("abort_in_ready",  a_in_ready,  0);
    @(negedge clk) rst_n = 1'b1;
    run_frame(BLINKER, 0, 0, -1, 1'b0);
    chk("gen_t5", a_gen, 1);

    // 6b: 2x2 all live -> every cell has 3 neighbours and survives
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    b_in_valid = 1'b1;
    b_in_cell  = 1'b1;
    k = 0;
    cyc = 0;
    while (k < 4 && cyc < 100) begin
      @(negedge clk);
      fire = b_in_valid && b_in_ready;
      @(posedge clk); #1;
      if (fire) k++;
      cyc++;
    end
    b_in_valid = 1'b0;
    cyc = 0;
    while (b_outs.size() < 4 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("b_out_count", b_outs.size(), 4);
    foreach (b_outs[i]) begin
      chk("b_out_cell", b_outs[i][1], 1);
      chk("b_out_last", b_outs[i][0], (i == 3));
    end
    chk("b_done_pulses", b_done_cnt, 1);
    chk("b_gen", b_gen, 1);
    chk("b_busy", b_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
